// File: rtl/enigma_rotor_if.sv
// Rotor-side bus: position control, status and the two one-hot letter paths.
// The master drives control and letters; the rotor answers as slave.
interface enigma_rotor_if;
    logic        load;
    logic [4:0]  load_pos;
    logic [4:0]  load_ring;
    logic        step;
    logic [25:0] fwd_in;
    logic [25:0] fwd_out;
    logic [25:0] rev_in;
    logic [25:0] rev_out;
    logic [4:0]  pos;
    logic        at_notch;
    logic        turnover;

    modport master (
        output load,
        output load_pos,
        output load_ring,
        output step,
        output fwd_in,
        output rev_in,
        input  fwd_out,
        input  rev_out,
        input  pos,
        input  at_notch,
        input  turnover
    );

    modport slave (
        input  load,
        input  load_pos,
        input  load_ring,
        input  step,
        input  fwd_in,
        input  rev_in,
        output fwd_out,
        output rev_out,
        output pos,
        output at_notch,
        output turnover
    );
endinterface

// File: rtl/enigma_rotor.sv
// Single stepping Enigma rotor: registered position/ring/turnover and
// combinational forward and inverse substitution on one-hot letter buses.
module enigma_rotor #(
    parameter logic [8*26-1:0] WIRING = "EKMFLGDQVZNTOWYHXUSPAIBRCJ",
    parameter logic [7:0]      NOTCH  = "Q"
) (
    input logic          clk,
    input logic          rst_n,
    enigma_rotor_if.slave bus
);

    localparam logic [4:0] NOTCH_IDX = 5'(NOTCH - 8'd65);

    logic [4:0] pos;
    logic [4:0] ring;
    logic       turnover;
    logic [4:0] off;
    logic       at_notch;

    function automatic logic [4:0] red26(input logic [4:0] v);
        return (v >= 5'd26) ? 5'(v - 5'd26) : v;
    endfunction

    function automatic logic [4:0] add26(input logic [4:0] a,
                                         input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
    endfunction

    // Adds 26 before subtracting so the intermediate never goes negative.
    function automatic logic [4:0] sub26(input logic [4:0] a,
                                         input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + 6'd26 - {1'b0, b};
        return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
    endfunction

    function automatic logic [4:0] wire_at(input logic [4:0] c);
        logic [7:0] ch;
        ch = WIRING[(25 - int'(c)) * 8 +: 8];
        return 5'(ch - 8'd65);
    endfunction

    // Exit contact of entry contact i at the given offset.
    function automatic logic [4:0] map_one(input logic [4:0] i,
                                           input logic [4:0] o);
        return sub26(wire_at(add26(i, o)), o);
    endfunction

    function automatic logic [25:0] perm_fwd(input logic [25:0] x,
                                             input logic [4:0]  o);
        logic [25:0] y;
        logic [4:0]  j;
        y = '0;
        for (int i = 0; i < 26; i++) begin
            j = map_one(5'(i), o);
            y[j] = x[i];
        end
        return y;
    endfunction

    function automatic logic [25:0] perm_rev(input logic [25:0] x,
                                             input logic [4:0]  o);
        logic [25:0] y;
        logic [4:0]  j;
        y = '0;
        for (int i = 0; i < 26; i++) begin
            j = map_one(5'(i), o);
            y[i] = x[j];
        end
        return y;
    endfunction

    assign at_notch = (pos == NOTCH_IDX);
    assign off      = sub26(pos, ring);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos      <= '0;
            ring     <= '0;
            turnover <= 1'b0;
        end else if (bus.load) begin
            pos      <= red26(bus.load_pos);
            ring     <= red26(bus.load_ring);
            turnover <= 1'b0;
        end else if (bus.step) begin
            pos      <= (pos == 5'd25) ? 5'd0 : 5'(pos + 5'd1);
            turnover <= at_notch;
        end else begin
            turnover <= 1'b0;
        end
    end

    assign bus.fwd_out  = perm_fwd(bus.fwd_in, off);
    assign bus.rev_out  = perm_rev(bus.rev_in, off);
    assign bus.pos      = pos;
    assign bus.at_notch = at_notch;
    assign bus.turnover = turnover;

endmodule

// File: tb/tb_enigma_rotor.sv
// Scoreboard bench for enigma_rotor: expectations queued at drive time,
// popped and compared once outputs have settled.
module tb_enigma_rotor;

    logic clk = 1'b0;
    logic rst_n;

    enigma_rotor_if bus();

    enigma_rotor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam int K_POS   = 0;
    localparam int K_NOTCH = 1;
    localparam int K_TURN  = 2;
    localparam int K_FWD   = 3;
    localparam int K_REV   = 4;

    typedef struct {
        string       tag;
        int          kind;
        logic [25:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    string W = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    int    mpos, mring;
    logic  mturn;

    task automatic chk(input string tag, input logic [25:0] got,
                       input logic [25:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] observe(input int kind);
        case (kind)
            K_POS:   return 26'(bus.pos);
            K_NOTCH: return 26'(bus.at_notch);
            K_TURN:  return 26'(bus.turnover);
            K_FWD:   return bus.fwd_out;
            default: return bus.rev_out;
        endcase
    endfunction

    task automatic push(input string tag, input int kind,
                        input logic [25:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.kind), e.exp);
        end
    endtask

    function automatic int mletter(input int a);
        int off;
        off = (mpos - mring + 26) % 26;
        return (int'(W[(a + off) % 26]) - 65 - off + 26) % 26;
    endfunction

    function automatic logic [25:0] mfwd(input logic [25:0] v);
        logic [25:0] y;
        y = '0;
        for (int i = 0; i < 26; i++)
            if (v[i]) y[mletter(i)] = 1'b1;
        return y;
    endfunction

    function automatic int red(input int v);
        return (v >= 26) ? v - 26 : v;
    endfunction

    // Advance model and DUT by one clock using the inputs currently driven.
    task automatic tick();
        int   np;
        int   nr;
        logic nt;
        np = mpos;
        nr = mring;
        nt = 1'b0;
        if (bus.load) begin
            np = red(int'(bus.load_pos));
            nr = red(int'(bus.load_ring));
        end else if (bus.step) begin
            np = (mpos == 25) ? 0 : mpos + 1;
            nt = (mpos == 16);
        end
        @(posedge clk);
        #1;
        mpos  = np;
        mring = nr;
        mturn = nt;
    endtask

    task automatic load_pr(input int p, input int r);
        bus.load      = 1'b1;
        bus.load_pos  = 5'(p);
        bus.load_ring = 5'(r);
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        int          x;
        logic [25:0] v;
        logic [25:0] f;
        rst_n         = 1'b0;
        bus.load      = 1'b0;
        bus.load_pos  = '0;
        bus.load_ring = '0;
        bus.step      = 1'b0;
        bus.fwd_in    = '0;
        bus.rev_in    = '0;
        mpos  = 0;
        mring = 0;
        mturn = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        bus.fwd_in = 26'd1;
        bus.rev_in = 26'd1 << 4;
        push("rst_pos", K_POS, 26'd0);
        push("rst_turn", K_TURN, 26'd0);
        push("rst_notch", K_NOTCH, 26'd0);
        push("rst_fwd", K_FWD, 26'd1 << 4);
        push("rst_rev", K_REV, 26'd1);
        drain();

        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        push("step_pos", K_POS, 26'd1);
        push("step_turn", K_TURN, 26'd0);
        push("step_fwd", K_FWD, 26'd1 << 9);
        drain();

        load_pr(16, 0);
        push("q_pos", K_POS, 26'd16);
        push("q_notch", K_NOTCH, 26'd1);
        push("q_turn0", K_TURN, 26'd0);
        drain();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        push("q_step_pos", K_POS, 26'd17);
        push("q_step_notch", K_NOTCH, 26'd0);
        push("q_step_turn", K_TURN, 26'd1);
        drain();
        tick();
        push("q_turn_drop", K_TURN, 26'd0);
        drain();

        load_pr(25, 0);
        bus.step = 1'b1;
        tick();
        push("wrap_pos", K_POS, 26'd0);
        push("wrap_turn", K_TURN, 26'd0);
        drain();
        bus.load      = 1'b1;
        bus.load_pos  = 5'd5;
        bus.load_ring = 5'd0;
        tick();
        bus.load = 1'b0;
        bus.step = 1'b0;
        push("ld_wins_pos", K_POS, 26'd5);
        push("ld_wins_turn", K_TURN, 26'd0);
        drain();

        load_pr(30, 0);
        push("ld_mod_pos", K_POS, 26'd4);
        drain();
        load_pr(0, 1);
        bus.fwd_in = 26'd1;
        push("ring1_fwd", K_FWD, 26'd1 << 10);
        drain();

        load_pr(0, 27);
        bus.fwd_in = 26'd1;
        push("ring27_fwd", K_FWD, 26'd1 << 10);
        drain();

        bus.fwd_in = '0;
        bus.rev_in = '0;
        push("zero_fwd", K_FWD, 26'd0);
        push("zero_rev", K_REV, 26'd0);
        drain();

        v = 26'h0000_0007 | (26'd1 << 20);
        bus.fwd_in = v;
        push("multi_fwd", K_FWD, mfwd(v));
        drain();

        for (int k = 0; k < 40; k++) begin
            load_pr(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            x = int'($urandom_range(0, 25));
            f = 26'd1 << mletter(x);
            bus.fwd_in = 26'd1 << x;
            bus.rev_in = f;
            push("sw_pos", K_POS, 26'(mpos));
            push("sw_fwd", K_FWD, f);
            push("sw_rev", K_REV, 26'd1 << x);
            drain();
        end

        load_pr(14, 3);
        bus.step = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            push("hold_pos", K_POS, 26'(mpos));
            push("hold_turn", K_TURN, 26'(mturn));
            drain();
        end

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        mpos  = 0;
        mring = 0;
        mturn = 1'b0;
        bus.fwd_in = 26'd1;
        push("arst_pos", K_POS, 26'd0);
        push("arst_turn", K_TURN, 26'd0);
        push("arst_fwd", K_FWD, 26'd1 << 4);
        drain();
        bus.step = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        push("post_rst_pos", K_POS, 26'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
